// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
//  Shared constants for the UART receive path: FSM state encodings, the
//  character width and the lowest usable clocks-per-bit divisor.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int UART_DATA_W = 8;
  localparam int MIN_DIV     = 4;

endpackage

// File: rtl/uart_rx_core_sync_fifo.sv
`timescale 1ns/1ps
// sync_fifo
//  Single-clock first-word-fall-through FIFO. The head entry is always
//  visible on rdata; a pop when empty is ignored, and a push when full is
//  refused unless a pop happens in the same cycle.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  push, wdata  write request and data
//  pop          read request (advances the head)
//  rdata        head entry (stale contents when empty)
//  full, empty  occupancy flags
//  count        number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core
//  8N1 UART receiver. The serial line is brought into the clock domain by a
//  two-flop synchroniser, a start bit is qualified at its middle, data bits
//  are sampled mid-bit LSB first, and the stop bit decides between storing
//  the byte in the receive FIFO and raising a framing error.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  ser_rx       serial input, idle high, asynchronous to clk
//  baud_div     clocks per bit (clamped to at least 4), captured at start edge
//  rx_data      FIFO head byte; rx_valid = FIFO not empty; rx_ready pops
//  rx_count     FIFO occupancy
//  rx_busy      a frame is being received
//  frame_err    sticky: stop bit sampled low
//  overrun      sticky: a received byte was dropped because the FIFO was full
//  clear_err    clears both sticky flags (a same-cycle new error wins)
//  irq          rx_valid | frame_err | overrun
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ser_rx,
  input  logic [DIV_W-1:0]       baud_div,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   clear_err,
  output logic                   irq
);

  logic                   sync1;
  logic                   rx_s;
  logic [1:0]             state;
  logic                   armed;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       div_lat;
  logic [2:0]             idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   stop_smp;
  logic                   push;
  logic                   frame_set;
  logic                   overrun_set;
  logic                   fifo_full;
  logic                   fifo_empty;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_W'(MIN_DIV)) return DIV_W'(MIN_DIV);
    return d;
  endfunction

  // Synchroniser resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      rx_s  <= sync1;
    end
  end

  // The byte is pushed in the same cycle the stop bit is sampled, so it
  // appears on rx_data one clock later.
  assign stop_smp    = (state == ST_STOP) && (cnt == '0);
  assign push        = stop_smp && rx_s;
  assign frame_set   = stop_smp && !rx_s;
  assign overrun_set = push && fifo_full && !(rx_valid && rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      armed   <= 1'b0;
      cnt     <= '0;
      div_lat <= DIV_W'(MIN_DIV);
      idx     <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A line that was low out of reset or after a framing error must
          // go high once before a falling edge counts as a start bit.
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            div_lat <= clamp_div(baud_div);
            cnt     <= clamp_div(baud_div) >> 1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt   <= div_lat - 1'b1;
            idx   <= '0;
            state <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
            cnt   <= div_lat - 1'b1;
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop lets a start edge in the second half of the
          // stop bit be caught.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!rx_s) armed <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (overrun_set)    overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shreg),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_valid = !fifo_empty;
  assign rx_busy  = (state != ST_IDLE);
  assign irq      = rx_valid | frame_err | overrun;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             ser_rx    = 1'b1;
  logic [DIV_W-1:0] baud_div  = 16;
  logic             rx_ready  = 1'b0;
  logic             clear_err = 1'b0;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [CW-1:0]    rx_count;
  logic             rx_busy;
  logic             frame_err;
  logic             overrun;
  logic             irq;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes expected at the consumer, sticky flag state.
  logic [7:0] mq[$];
  logic [7:0] got_q[$];
  bit         exp_ferr = 0;
  bit         exp_ovr  = 0;
  bit         busy_seen;

  always #12.5 clk = ~clk;

  uart_rx_core #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_rx    (ser_rx),
    .baud_div  (baud_div),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clear_err (clear_err),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer monitor: a byte leaves the FIFO at the next posedge whenever
  // rx_valid && rx_ready hold in the second half of the cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_busy) busy_seen = 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model of one complete frame: the bytes the receiver should deliver and
  // the flags it should raise.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr = 1;
    else if (rx_ready || mq.size() < DEPTH) mq.push_back(b);
    else exp_ovr = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    model_frame(b, stop);
    ser_rx = 1'b0;
    cycles(d);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      cycles(d);
    end
    ser_rx = stop;
    cycles(d);
    ser_rx = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    for (int i = 0; i < 3000 && got_q.size() < mq.size(); i++) cycles(1);
    cycles(3);
    chk({tag, "_count"}, got_q.size(), mq.size());
    while (got_q.size() > 0 && mq.size() > 0)
      chk({tag, "_byte"}, got_q.pop_front(), mq.pop_front());
    got_q.delete();
    mq.delete();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    exp_ferr  = 0;
    exp_ovr   = 0;
    cycles(1);
  endtask

  initial begin
    int d;
    logic [7:0] b;
    logic st;

    // Reset values
    cycles(3);
    chk("rst_rx_valid",  rx_valid,  0);
    chk("rst_rx_data",   rx_data,   0);
    chk("rst_rx_count",  rx_count,  0);
    chk("rst_rx_busy",   rx_busy,   0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun",   overrun,   0);
    chk("rst_irq",       irq,       0);
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    cycles(5);

    // Two frames delivered in order
    send_frame(8'h0F, 1'b1, 16);
    send_frame(8'h3D, 1'b1, 16);
    check_rx("t1");
    chk("t1_frame_err", frame_err, exp_ferr);
    chk("t1_overrun",   overrun,   exp_ovr);

    // Framing error, clear, then recovery
    send_frame(8'hA5, 1'b0, 16);
    cycles(4);
    chk("t2_frame_err", frame_err, exp_ferr);
    chk("t2_irq",       irq,       1);
    chk("t2_rx_valid",  rx_valid,  0);
    pulse_clear();
    chk("t2_cleared",   frame_err, exp_ferr);
    cycles(20);
    send_frame(8'h5A, 1'b1, 16);
    check_rx("t2");

    // Overrun with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 16);
    cycles(10);
    chk("t3_rx_count", rx_count, DEPTH);
    chk("t3_overrun",  overrun,  exp_ovr);
    chk("t3_rx_data",  rx_data,  mq[0]);
    chk("t3_irq",      irq,      1);
    pulse_clear();
    chk("t3_cleared",  overrun,  exp_ovr);
    rx_ready = 1'b1;
    check_rx("t3");

    // Short low glitch is rejected silently
    busy_seen = 0;
    ser_rx = 1'b0;
    cycles(6);
    ser_rx = 1'b1;
    cycles(40);
    chk("t4_busy_seen", busy_seen, 1);
    chk("t4_rx_busy",   rx_busy,   0);
    chk("t4_rx_valid",  rx_valid,  0);
    chk("t4_frame_err", frame_err, 0);
    chk("t4_overrun",   overrun,   0);

    // Reset in the middle of a frame
    rx_ready = 1'b0;
    b = 8'hC3;
    ser_rx = 1'b0;
    cycles(16);
    for (int i = 0; i < 3; i++) begin
      ser_rx = b[i];
      cycles(16);
    end
    ser_rx = b[3];
    cycles(8);
    rst_n = 1'b0;
    cycles(3);
    chk("t5_rst_busy",  rx_busy,  0);
    chk("t5_rst_count", rx_count, 0);
    ser_rx = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    send_frame(8'h7E, 1'b1, 16);
    cycles(4);
    chk("t5_rx_count", rx_count, 1);
    chk("t5_rx_data",  rx_data,  8'h7E);
    rx_ready = 1'b1;
    check_rx("t5");

    // Divisor clamp
    baud_div = 2;
    send_frame(8'h81, 1'b1, 4);
    check_rx("t6_clamp");

    // Random frames at random rates, mostly back-to-back
    for (int n = 0; n < 40; n++) begin
      d  = $urandom_range(4, 20);
      baud_div = (d == 4) ? DIV_W'($urandom_range(0, 4)) : DIV_W'(d);
      b  = 8'($urandom);
      st = ($urandom_range(0, 9) != 0);
      send_frame(b, st, d);
      // After a bad stop bit the line must be seen high before a new start.
      if (!st) cycles(d);
      else if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 30));
    end
    check_rx("t6_rand");
    chk("t6_frame_err", frame_err, exp_ferr);
    chk("t6_overrun",   overrun,   exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
